// File: rtl/fft_pkg.sv
// Shared FFT datapath types and the saturating shift used by both butterfly directions.
package fft_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_FRAC_BITS  = 15;
  localparam int unsigned SAT_W          = 64;

  // Complex sample at the default width. Wider internal values use plain
  // signed vectors because a package typedef cannot take a width parameter.
  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] re;
    logic signed [DEF_DATA_WIDTH-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  // Arithmetic right shift (optionally round-half-up), then clamp to out_width bits.
  function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] value,
                                         input int unsigned             shift,
                                         input int unsigned             out_width,
                                         input logic                    rnd);
    logic signed [SAT_W-1:0] v;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                r;
    v = value;
    if (rnd && (shift != 0)) begin
      v = v + (SAT_W'(1) <<< (shift - 1));
    end
    v  = v >>> shift;
    hi = (SAT_W'(1) <<< (out_width - 1)) - SAT_W'(1);
    lo = -(SAT_W'(1) <<< (out_width - 1));
    r.sat = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (v < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cplx_conj_mul.sv
// Two-stage conjugate complex rotation: registered products, then combine, shift and saturate.
module cplx_conj_mul
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IN_WIDTH   = DEF_DATA_WIDTH + 2,
  parameter int unsigned SHIFT      = DEF_FRAC_BITS + 1,
  parameter bit          ROUND_EN   = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic signed [IN_WIDTH-1:0]   d_re_i,
  input  logic signed [IN_WIDTH-1:0]   d_im_i,
  input  logic signed [DATA_WIDTH-1:0] tw_re_i,
  input  logic signed [DATA_WIDTH-1:0] tw_im_i,
  output logic signed [DATA_WIDTH-1:0] re_o,
  output logic signed [DATA_WIDTH-1:0] im_o,
  output logic                         sat_o
);

  localparam int unsigned PW = IN_WIDTH + DATA_WIDTH;
  localparam int unsigned RW = PW + 1;

  logic signed [PW-1:0] p_rr_d, p_rr_q;
  logic signed [PW-1:0] p_ii_d, p_ii_q;
  logic signed [PW-1:0] p_ir_d, p_ir_q;
  logic signed [PW-1:0] p_ri_d, p_ri_q;
  logic signed [RW-1:0] rot_re, rot_im;
  sat_res_t             res_re, res_im;
  logic signed [DATA_WIDTH-1:0] re_d, re_q, im_d, im_q;
  logic                 sat_d, sat_q;

  always_comb begin
    p_rr_d = p_rr_q;
    p_ii_d = p_ii_q;
    p_ir_d = p_ir_q;
    p_ri_d = p_ri_q;
    re_d   = re_q;
    im_d   = im_q;
    sat_d  = sat_q;
    // Multiplying by conj(W) turns the cross-term signs around relative to a plain product.
    rot_re = RW'(p_rr_q) + RW'(p_ii_q);
    rot_im = RW'(p_ir_q) - RW'(p_ri_q);
    res_re = sat_shift(SAT_W'(rot_re), SHIFT, DATA_WIDTH, ROUND_EN);
    res_im = sat_shift(SAT_W'(rot_im), SHIFT, DATA_WIDTH, ROUND_EN);
    if (en_i) begin
      p_rr_d = PW'(d_re_i) * PW'(tw_re_i);
      p_ii_d = PW'(d_im_i) * PW'(tw_im_i);
      p_ir_d = PW'(d_im_i) * PW'(tw_re_i);
      p_ri_d = PW'(d_re_i) * PW'(tw_im_i);
      re_d   = DATA_WIDTH'(res_re.val);
      im_d   = DATA_WIDTH'(res_im.val);
      sat_d  = res_re.sat | res_im.sat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ir_q <= '0;
      p_ri_q <= '0;
      re_q   <= '0;
      im_q   <= '0;
      sat_q  <= 1'b0;
    end else begin
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ir_q <= p_ir_d;
      p_ri_q <= p_ri_d;
      re_q   <= re_d;
      im_q   <= im_d;
      sat_q  <= sat_d;
    end
  end

  assign re_o  = re_q;
  assign im_o  = im_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/inv_butterfly_pipe.sv
// Three-stage radix-2 inverse (Gentleman-Sande) butterfly with valid/ready flow control.
// Define INV_BFLY_ROUND_EN to round half-up before each right shift instead of truncating.
module inv_butterfly_pipe
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic signed [DATA_WIDTH-1:0] twid_i [2],
  input  logic signed [DATA_WIDTH:0]   a_i    [2],
  input  logic signed [DATA_WIDTH:0]   b_i    [2],
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic signed [DATA_WIDTH-1:0] a_o    [2],
  output logic signed [DATA_WIDTH-1:0] b_o    [2],
  output logic                         sat_o
);

`ifdef INV_BFLY_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam int unsigned SW = DATA_WIDTH + 2;

  logic en;
  logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;

  logic signed [SW-1:0]         s_d   [2];
  logic signed [SW-1:0]         s_q   [2];
  logic signed [SW-1:0]         d_d   [2];
  logic signed [SW-1:0]         d_q   [2];
  logic signed [DATA_WIDTH-1:0] tw_d  [2];
  logic signed [DATA_WIDTH-1:0] tw_q  [2];
  logic signed [SW-1:0]         s2_d  [2];
  logic signed [SW-1:0]         s2_q  [2];
  logic signed [DATA_WIDTH-1:0] ao_d  [2];
  logic signed [DATA_WIDTH-1:0] ao_q  [2];
  sat_res_t                     a_res [2];
  logic                         asat_d, asat_q;
  logic                         rot_sat;

  // The whole pipe advances together; a stalled output freezes every stage.
  assign en      = ~v3_q | ready_i;
  assign ready_o = en;

  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    s_d    = s_q;
    d_d    = d_q;
    tw_d   = tw_q;
    s2_d   = s2_q;
    ao_d   = ao_q;
    asat_d = asat_q;
    for (int unsigned i = 0; i < 2; i++) begin
      a_res[i] = sat_shift(SAT_W'(s2_q[i]), 1, DATA_WIDTH, ROUND_EN);
    end
    if (en) begin
      v1_d = valid_i;
      v2_d = v1_q;
      v3_d = v2_q;
      for (int unsigned i = 0; i < 2; i++) begin
        s_d[i]  = SW'(a_i[i]) + SW'(b_i[i]);
        d_d[i]  = SW'(a_i[i]) - SW'(b_i[i]);
        tw_d[i] = twid_i[i];
        s2_d[i] = s_q[i];
        ao_d[i] = DATA_WIDTH'(a_res[i].val);
      end
      asat_d = a_res[0].sat | a_res[1].sat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      s_q    <= '{default: '0};
      d_q    <= '{default: '0};
      tw_q   <= '{default: '0};
      s2_q   <= '{default: '0};
      ao_q   <= '{default: '0};
      asat_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      s_q    <= s_d;
      d_q    <= d_d;
      tw_q   <= tw_d;
      s2_q   <= s2_d;
      ao_q   <= ao_d;
      asat_q <= asat_d;
    end
  end

  cplx_conj_mul #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_WIDTH   (SW),
    .SHIFT      (FRAC_BITS + 1),
    .ROUND_EN   (ROUND_EN)
  ) u_rot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en),
    .d_re_i  (d_q[0]),
    .d_im_i  (d_q[1]),
    .tw_re_i (tw_q[0]),
    .tw_im_i (tw_q[1]),
    .re_o    (b_o[0]),
    .im_o    (b_o[1]),
    .sat_o   (rot_sat)
  );

  assign valid_o = v3_q;
  assign a_o     = ao_q;
  assign sat_o   = asat_q | rot_sat;

endmodule

// File: tb/tb_inv_butterfly_pipe.sv
// Self-checking bench for inv_butterfly_pipe: directed cases, backpressure, reset flush, random round-trips.
`timescale 1ns/1ps
module tb_inv_butterfly_pipe;

  localparam int DW = 16;
  localparam int FB = 15;
`ifdef INV_BFLY_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, valid_i, ready_o, valid_o, ready_i, sat_o;
  logic signed [DW-1:0] twid_i [2];
  logic signed [DW:0]   a_i    [2];
  logic signed [DW:0]   b_i    [2];
  logic signed [DW-1:0] a_o    [2];
  logic signed [DW-1:0] b_o    [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inv_butterfly_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .twid_i(twid_i), .a_i(a_i), .b_i(b_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .a_o(a_o), .b_o(b_o), .sat_o(sat_o)
  );

  typedef struct {
    longint ar, ai, br, bi;
    bit     sat;
    bit     has_orig;
    longint oar, oai, obr, obi;
  } exp_t;

  exp_t   sb [$];
  longint cur_a [2], cur_b [2], cur_t [2];
  bit     cur_has_orig;
  longint cur_oa [2], cur_ob [2];
  bit     last_in, hold_pend;
  int     n_out;
  logic signed [DW-1:0] held_a [2], held_b [2];
  logic   held_sat;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(longint x, longint d);
    longint q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint scale_down(longint x, longint d);
    return RND ? floor_div(x + d / 2, d) : floor_div(x, d);
  endfunction

  function automatic longint clamp(longint x);
    longint hi, lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  // a = (A+B)/2, b = (A-B)*conj(W)/2 with W in Q1.FB, then clamp.
  function automatic exp_t model(longint ar, longint ai, longint br, longint bi, longint tr, longint ti);
    exp_t   e;
    longint sr, si, dr, di, rr, ri, xa, xb, xc, xd;
    sr = ar + br;  si = ai + bi;
    dr = ar - br;  di = ai - bi;
    rr = dr * tr + di * ti;
    ri = di * tr - dr * ti;
    xa = scale_down(sr, 2);
    xb = scale_down(si, 2);
    xc = scale_down(rr, longint'(1) << (FB + 1));
    xd = scale_down(ri, longint'(1) << (FB + 1));
    e.ar = clamp(xa); e.ai = clamp(xb); e.br = clamp(xc); e.bi = clamp(xd);
    e.sat = (e.ar != xa) || (e.ai != xb) || (e.br != xc) || (e.bi != xd);
    e.has_orig = 1'b0;
    e.oar = 0; e.oai = 0; e.obr = 0; e.obi = 0;
    return e;
  endfunction

  task automatic set_in(input longint ar, input longint ai, input longint br, input longint bi,
                        input longint tr, input longint ti);
    cur_a[0] = ar; cur_a[1] = ai; cur_b[0] = br; cur_b[1] = bi; cur_t[0] = tr; cur_t[1] = ti;
    a_i[0] = ar[DW:0]; a_i[1] = ai[DW:0];
    b_i[0] = br[DW:0]; b_i[1] = bi[DW:0];
    twid_i[0] = tr[DW-1:0]; twid_i[1] = ti[DW-1:0];
  endtask

  // One clock: check outputs/handshake, retire or enqueue beats, return at the next falling edge.
  task automatic step();
    exp_t   e, pend;
    bit     inf, outf;
    longint er, ei;
    #1;
    inf  = valid_i && ready_o;
    outf = valid_o && ready_i;
    chk("ready_o", ready_o, !(valid_o && !ready_i));
    if (hold_pend) begin
      chk("hold_valid", valid_o, 1);
      chk("hold_a_re", a_o[0], held_a[0]);
      chk("hold_a_im", a_o[1], held_a[1]);
      chk("hold_b_re", b_o[0], held_b[0]);
      chk("hold_b_im", b_o[1], held_b[1]);
      chk("hold_sat", sat_o, held_sat);
    end
    if (outf) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("a_re", a_o[0], e.ar);
        chk("a_im", a_o[1], e.ai);
        chk("b_re", b_o[0], e.br);
        chk("b_im", b_o[1], e.bi);
        chk("sat", sat_o, e.sat);
        if (e.has_orig) begin
          chk("rt_a_re", a_o[0], e.oar);
          chk("rt_a_im", a_o[1], e.oai);
          er = longint'(b_o[0]) - e.obr;
          ei = longint'(b_o[1]) - e.obi;
          chk("rt_b_re_err_le2", (er <= 2 && er >= -2), 1);
          chk("rt_b_im_err_le2", (ei <= 2 && ei >= -2), 1);
        end
      end
    end
    hold_pend = valid_o && !ready_i;
    held_a = a_o; held_b = b_o; held_sat = sat_o;
    pend = model(cur_a[0], cur_a[1], cur_b[0], cur_b[1], cur_t[0], cur_t[1]);
    pend.has_orig = cur_has_orig;
    pend.oar = cur_oa[0]; pend.oai = cur_oa[1]; pend.obr = cur_ob[0]; pend.obi = cur_ob[1];
    last_in = inf;
    @(posedge clk);
    if (inf) sb.push_back(pend);
    @(negedge clk);
  endtask

  task automatic single(input string tag, input longint ar, input longint ai, input longint br,
                        input longint bi, input longint tr, input longint ti,
                        input longint ear, input longint eai, input longint ebr, input longint ebi);
    int n;
    set_in(ar, ai, br, bi, tr, ti);
    valid_i = 1'b1; ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    n = 1;
    while (!valid_o && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_a_re"}, a_o[0], ear);
    chk({tag, "_a_im"}, a_o[1], eai);
    chk({tag, "_b_re"}, b_o[0], ebr);
    chk({tag, "_b_im"}, b_o[1], ebi);
    step();
  endtask

  function automatic longint rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return longint'($signed(r));
  endfunction

  function automatic longint rnd17();
    logic [16:0] r;
    r = 17'($urandom);
    return longint'($signed(r));
  endfunction

  // Reference forward butterfly with truncating twiddle product.
  task automatic load_roundtrip();
    longint oa [2], ob [2], tw [2], wr, wi;
    oa[0] = rnd16(); oa[1] = rnd16(); ob[0] = rnd16(); ob[1] = rnd16();
    case ($urandom_range(0, 3))
      0: begin tw[0] = 32767;  tw[1] = 0;      end
      1: begin tw[0] = 0;      tw[1] = 32767;  end
      2: begin tw[0] = -32768; tw[1] = 0;      end
      default: begin tw[0] = 0; tw[1] = -32768; end
    endcase
    wr = floor_div(ob[0] * tw[0] - ob[1] * tw[1], longint'(1) << FB);
    wi = floor_div(ob[0] * tw[1] + ob[1] * tw[0], longint'(1) << FB);
    set_in(oa[0] + wr, oa[1] + wi, oa[0] - wr, oa[1] - wi, tw[0], tw[1]);
    cur_has_orig = 1'b1;
    cur_oa = oa; cur_ob = ob;
  endtask

  initial begin
    int accepted, iter;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    cur_has_orig = 1'b0; cur_oa = '{0, 0}; cur_ob = '{0, 0};
    hold_pend = 1'b0; last_in = 1'b0; n_out = 0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_a_re", a_o[0], 0);
    chk("rst_b_im", b_o[1], 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_ready_o", ready_o, 1);
    @(negedge clk);

    single("roundtrip", 1199, -1701, 801, -2299, 32767, 0, 1000, -2000, RND ? 199 : 198, RND ? 299 : 298);
    chk("roundtrip_sat_model", sat_o, sat_o);
    single("exact_tw", 0, 0, 100, 0, 0, -32768, 50, 0, 0, -50);
    single("sat_pos", 65535, 0, 65535, 0, 32767, 0, 32767, 0, 0, 0);
    // -65536 lies below the output range, so the clamp fires here too.
    single("sat_neg", -65536, 0, -65536, 0, 32767, 0, -32768, 0, 0, 0);

    // Backpressure: 8 beats with ready_i pattern 1,0,0,1,...
    n_out = 0; accepted = 0; iter = 0;
    set_in(rnd17(), rnd17(), rnd17(), rnd17(), rnd16(), rnd16());
    while ((accepted < 8 || sb.size() != 0) && iter < 200) begin
      valid_i = (accepted < 8);
      ready_i = ((iter % 4) == 0) || ((iter % 4) == 3);
      step();
      if (last_in) begin
        accepted++;
        set_in(rnd17(), rnd17(), rnd17(), rnd17(), rnd16(), rnd16());
      end
      iter++;
    end
    valid_i = 1'b0; ready_i = 1'b1; hold_pend = 1'b0;
    chk("bp_beats_out", n_out, 8);
    chk("bp_drained", sb.size(), 0);

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) begin
      set_in(rnd17(), rnd17(), rnd17(), rnd17(), rnd16(), rnd16());
      valid_i = 1'b1; ready_i = 1'b0;
      step();
    end
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    hold_pend = 1'b0;
    #1;
    chk("flush_valid_o", valid_o, 0);
    chk("flush_a_re", a_o[0], 0);
    chk("flush_a_im", a_o[1], 0);
    chk("flush_b_re", b_o[0], 0);
    chk("flush_b_im", b_o[1], 0);
    chk("flush_sat", sat_o, 0);
    chk("flush_ready_o", ready_o, 1);
    @(negedge clk);
    ready_i = 1'b1;
    repeat (6) step();
    single("post_rst", 1199, -1701, 801, -2299, 32767, 0, 1000, -2000, RND ? 199 : 198, RND ? 299 : 298);

    // Random round-trips through the reference forward butterfly.
    accepted = 0; iter = 0;
    load_roundtrip();
    while (accepted < 10000 && iter < 40000) begin
      valid_i = ($urandom_range(0, 9) < 8);
      ready_i = ($urandom_range(0, 3) != 0);
      step();
      if (last_in) begin
        accepted++;
        load_roundtrip();
      end
      iter++;
    end
    chk("rt_accepted", accepted, 10000);

    // Raw random operands, including saturating ones.
    cur_has_orig = 1'b0;
    accepted = 0; iter = 0;
    set_in(rnd17(), rnd17(), rnd17(), rnd17(), rnd16(), rnd16());
    while (accepted < 2000 && iter < 10000) begin
      valid_i = ($urandom_range(0, 9) < 8);
      ready_i = ($urandom_range(0, 3) != 0);
      step();
      if (last_in) begin
        accepted++;
        set_in(rnd17(), rnd17(), rnd17(), rnd17(), rnd16(), rnd16());
      end
      iter++;
    end
    chk("raw_accepted", accepted, 2000);

    valid_i = 1'b0; ready_i = 1'b1;
    iter = 0;
    while (sb.size() != 0 && iter < 20) begin
      step();
      iter++;
    end
    chk("final_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
